// File: rtl/gals_pkg.sv
// Shared definitions for the GALS bundled-data link: handshake FSM states and
// default widths/depths used by both the sender and the receiver side.
package gals_pkg;

    localparam int DW_DEF       = 16;
    localparam int DEPTH_DEF    = 4;
    localparam int SYNC_STG_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } hs_state_t;

endpackage

// File: rtl/hs_sync.sv
// Multi-flop level synchronizer for an asynchronous handshake wire.
// Used for ack on the sender side and for req on the receiver side.
module hs_sync
    import gals_pkg::*;
#(
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STG-1:0] sync_q;
    logic [SYNC_STG-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STG-1];

endmodule

// File: rtl/gals_hs_tx.sv
// Four-phase bundled-data sender: buffers core words in a small FIFO and
// presents each on a held tx_data bus qualified by a registered req level.
module gals_hs_tx
    import gals_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          req,
    output logic [DW-1:0] tx_data,
    input  logic          ack,
    output logic          busy,
    output logic          tx_done,
    output logic [1:0]    state_dbg
);

    localparam int AW = $clog2(DEPTH);

    hs_state_t     state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          req_q, req_d;
    logic          tx_done_q, tx_done_d;
    logic          ack_s;
    logic          empty, full, push, pop;

    hs_sync #(.SYNC_STG(SYNC_STG)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack),
        .q     (ack_s)
    );

    // Input side: a word moves when in_valid && in_ready at a rising clk edge;
    // in_ready depends on the registered pointers only, never on in_valid.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // A stale ack still high from the previous transfer blocks a new start.
    assign pop      = (state_q == IDLE) && !empty && !ack_s;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // SETUP ignores ack_s so the data bus settles a full cycle before req rises.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        tx_data_d = tx_data_q;
        tx_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                req_d   = 1'b1;
                state_d = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tx_data_q <= '0;
            req_q     <= 1'b0;
            tx_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tx_data_q <= tx_data_d;
            req_q     <= req_d;
            tx_done_q <= tx_done_d;
            mem_q     <= mem_d;
        end
    end

    assign req       = req_q;
    assign tx_data   = tx_data_q;
    assign tx_done   = tx_done_q;
    assign busy      = !empty || (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gals_hs_tx.sv
// Directed bench for gals_hs_tx: receiver model, in-order scoreboard on req
// rising edges, and hand-timed checks of latency, back-pressure and reset.
module tb_gals_hs_tx;

  localparam int DW       = 16;
  localparam int DEPTH    = 4;
  localparam int SYNC_STG = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_REQ_HI = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          req;
  logic [DW-1:0] tx_data;
  logic          ack;
  logic          busy;
  logic          tx_done;
  logic [1:0]    state_dbg;

  gals_hs_tx #(.DW(DW), .DEPTH(DEPTH), .SYNC_STG(SYNC_STG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .tx_data   (tx_data),
    .ack       (ack),
    .busy      (busy),
    .tx_done   (tx_done),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- receiver model ----------------
  logic rx_en     = 1'b0;
  logic ack_man   = 1'b0;
  logic ack_model = 1'b0;
  int   rx_dly    = 1;
  int   rx_cnt    = 0;

  assign ack = rx_en ? ack_model : ack_man;

  always @(negedge clk) begin
    if (!rx_en) begin
      ack_model = 1'b0;
      rx_cnt    = 0;
    end else if (!ack_model) begin
      if (req) begin
        rx_cnt++;
        if (rx_cnt >= rx_dly) begin ack_model = 1'b1; rx_cnt = 0; end
      end else begin
        rx_cnt = 0;
      end
    end else begin
      if (!req) begin
        rx_cnt++;
        if (rx_cnt >= rx_dly) begin ack_model = 1'b0; rx_cnt = 0; end
      end else begin
        rx_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held     = '0;
  logic          req_prev = 1'b0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (tx_done) done_cnt++;
      if (req && !req_prev) begin
        if (exp_q.size() == 0) begin
          check("req_without_word", 32'(req), 32'd0);
        end else begin
          held = exp_q.pop_front();
          check("tx_data_at_req", 32'(tx_data), 32'(held));
        end
      end
      if (!req && req_prev) check("tx_data_hold", 32'(tx_data), 32'(held));
      req_prev = req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [DW-1:0] w, input int budget);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        exp_q.push_back(w);
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("push_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !req) begin ok = 1'b1; break; end
    end
    if (!ok) check(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int   d0;
  logic ok;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req", 32'(req), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, receiver with 3-cycle ack delays
    rx_en  = 1'b1;
    rx_dly = 3;
    d0     = done_cnt;
    @(negedge clk);
    check("t2_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'hA5A5;
    exp_q.push_back(16'hA5A5);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("t2_req_e0", 32'(req), 32'd0);
    @(posedge clk);
    #1 check("t2_req_e1", 32'(req), 32'd0);
    check("t2_state_e1", 32'(state_dbg), 32'(S_SETUP));
    check("t2_txdata_e1", 32'(tx_data), 32'h0000A5A5);
    @(posedge clk);
    #1 check("t2_req_e2", 32'(req), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_done) begin ok = 1'b1; break; end
    end
    check("t2_done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    check("t2_done_one_cycle", 32'(tx_done), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t2_done_count", 32'(done_cnt - d0), 32'd1);

    // Six words into DEPTH=4 with a stalled receiver
    rx_en   = 1'b0;
    ack_man = 1'b0;
    d0      = done_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(i);
      check($sformatf("t3_ready_w%0d", i), 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
      if (in_ready) exp_q.push_back(DW'(i));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_held_off", 32'(in_ready), 32'd0);
    end
    check("t3_req_stalled", 32'(req), 32'd1);
    rx_en  = 1'b1;
    rx_dly = 1;
    ok     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(DW'(5));
        @(posedge clk);
        #1 in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("t3_w5_accepted", 32'(ok), 32'd1);
    wait_drain("t3_drain_timeout", 400);
    check("t3_done_count", 32'(done_cnt - d0), 32'd6);

    // ack held high from reset blocks any start
    rx_en   = 1'b0;
    ack_man = 1'b1;
    do_reset();
    push_word(16'h1234, 4);
    repeat (10) @(negedge clk);
    check("t4_req_blocked", 32'(req), 32'd0);
    check("t4_state_idle", 32'(state_dbg), 32'(S_IDLE));
    check("t4_busy", 32'(busy), 32'd1);
    ack_man = 1'b0;
    ok      = 1'b0;
    for (int k = 0; k < SYNC_STG + 2; k++) begin
      @(posedge clk);
      #1;
      if (state_dbg != S_IDLE) begin ok = 1'b1; break; end
    end
    check("t4_start_after_drop", 32'(ok), 32'd1);
    rx_en  = 1'b1;
    rx_dly = 1;
    d0     = done_cnt;
    wait_drain("t4_drain_timeout", 100);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);

    // Push on the pop edge at occupancy 2, running past a pointer wrap
    rx_en   = 1'b0;
    ack_man = 1'b0;
    d0      = done_cnt;
    for (int k = 0; k < 3; k++) push_word(16'h0100 + DW'(k), 10);
    rx_en  = 1'b1;
    rx_dly = 1;
    for (int k = 3; k < 3 + 2 * DEPTH; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (tx_done) begin ok = 1'b1; break; end
      end
      check($sformatf("t5_done_w%0d", k), 32'(ok), 32'd1);
      check($sformatf("t5_ready_w%0d", k), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 16'h0100 + DW'(k);
      exp_q.push_back(16'h0100 + DW'(k));
      @(posedge clk);
      #1 in_valid = 1'b0;
      check($sformatf("t5_pop_w%0d", k), 32'(state_dbg), 32'(S_SETUP));
    end
    wait_drain("t5_drain_timeout", 400);
    check("t5_done_count", 32'(done_cnt - d0), 32'(3 + 2 * DEPTH));

    // Synchronized ack high only while in SETUP must be ignored
    rx_en   = 1'b0;
    ack_man = 1'b0;
    d0      = done_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    ack_man  = 1'b1;
    exp_q.push_back(16'hBEEF);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ack_man  = 1'b0;
    @(posedge clk);
    #1 check("t6_state_e1", 32'(state_dbg), 32'(S_SETUP));
    @(posedge clk);
    #1 check("t6_state_e2", 32'(state_dbg), 32'(S_REQ_HI));
    check("t6_req_e2", 32'(req), 32'd1);
    @(posedge clk);
    #1 check("t6_state_e3", 32'(state_dbg), 32'(S_REQ_HI));
    @(posedge clk);
    #1 check("t6_req_e4", 32'(req), 32'd1);
    rx_en  = 1'b1;
    rx_dly = 2;
    wait_drain("t6_drain_timeout", 100);
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset in REQ_HI with three words queued
    rx_en   = 1'b0;
    ack_man = 1'b0;
    for (int k = 0; k < 4; k++) push_word(16'hC000 + DW'(k), 10);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_dbg == S_REQ_HI) begin ok = 1'b1; break; end
    end
    check("t7_in_req_hi", 32'(ok), 32'd1);
    check("t7_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("t7_req_dropped", 32'(req), 32'd0);
    check("t7_busy_rst", 32'(busy), 32'd0);
    check("t7_ready_rst", 32'(in_ready), 32'd1);
    check("t7_txdata_rst", 32'(tx_data), 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t7_no_done", 32'(done_cnt - d0), 32'd0);
    check("t7_busy_after", 32'(busy), 32'd0);
    check("t7_req_after", 32'(req), 32'd0);
    check("t7_ready_after", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1);
  end

endmodule
